// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first,
// through a full-subtractor cell with a registered borrow. Results are
// reported with a single-cycle done pulse and held until the next completion.
module bit_serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    // Full-subtractor cell on the current operand LSBs and the borrow flop.
    logic ai, bi, bin, d_bit, bnext;
    assign ai    = a_q[0];
    assign bi    = b_q[0];
    assign bin   = brw_q;
    assign d_bit = ai ^ bi ^ bin;
    assign bnext = (~ai & bi) | (~(ai ^ bi) & bin);

    // State register and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath update; everything holds unless a state acts on it.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    amsb_d  = a[WIDTH-1];
                    bmsb_d  = b[WIDTH-1];
                    res_d   = '0;
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_d = {d_bit, res_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                brw_d = bnext;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Result registers load on the edge entering DONE so they
                    // are already valid while done is high; d_bit is the MSB here.
                    diff_d  = res_d;
                    bout_d  = bnext;
                    ovf_d   = (amsb_q ^ bmsb_q) & (d_bit ^ amsb_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = bout_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed testbench for bit_serial_subtractor with hand-computed results.
module tb_bit_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         ovf;

    int n_cmp;
    int n_bad;

    bit_serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one subtraction starting at the next negedge and check timing and results.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ed, input logic eb, input logic eo);
        int cycles;
        int busy_cnt;
        string t;
        t = $sformatf("%0h-%0h", av, bv);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~av;
        b = ~bv;
        cycles = 0;
        busy_cnt = 0;
        while (!done && cycles < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        check_eq({t, " latency"}, cycles, W);
        check_eq({t, " busy_cycles"}, busy_cnt, W);
        check_eq({t, " busy_in_done"}, busy, 1'b0);
        check_eq({t, " diff"}, diff, ed);
        check_eq({t, " borrow"}, borrow_out, eb);
        check_eq({t, " ovf"}, ovf, eo);
    endtask

    initial begin
        int dones;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst busy", busy, 1'b0);
        check_eq("rst done", done, 1'b0);
        check_eq("rst diff", diff, 8'h00);
        check_eq("rst borrow", borrow_out, 1'b0);
        check_eq("rst ovf", ovf, 1'b0);
        rst_n = 1'b1;

        // Basic, borrow, signed overflow and boundary operands.
        run_op(8'd100, 8'd37, 8'd63, 1'b0, 1'b0);
        run_op(8'd5,   8'd9,  8'hFC, 1'b1, 1'b0);
        run_op(8'h80,  8'h01, 8'h7F, 1'b0, 1'b1);
        run_op(8'h7F,  8'hFF, 8'h80, 1'b1, 1'b1);
        run_op(8'hA5,  8'hA5, 8'h00, 1'b0, 1'b0);
        run_op(8'h00,  8'h00, 8'h00, 1'b0, 1'b0);
        run_op(8'hFF,  8'h00, 8'hFF, 1'b0, 1'b0);
        run_op(8'h00,  8'h01, 8'hFF, 1'b1, 1'b0);

        // Extra starts during SHIFT and DONE are ignored; operand changes have no effect.
        @(negedge clk);
        a = 8'd10;
        b = 8'd3;
        start = 1'b1;
        dones = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (i == 5) check_eq("hold diff mid-run", diff, 8'hFF);
            start = (i == 3 || i == 8 || i == 9);
            a = 8'd1;
            b = 8'd2;
        end
        check_eq("ignore done_at_9", done, 1'b1);
        check_eq("ignore done_count", dones, 1);
        check_eq("ignore diff", diff, 8'd7);
        check_eq("ignore borrow", borrow_out, 1'b0);
        // The start held during DONE must not launch an operation.
        @(negedge clk);
        start = 1'b0;
        check_eq("ignore no_restart busy", busy, 1'b0);
        check_eq("ignore no_second_done", done, 1'b0);
        // Back-to-back issue from IDLE right after the previous completion.
        run_op(8'h33, 8'h11, 8'h22, 1'b0, 1'b0);

        // Reset mid-operation aborts and clears outputs without a done pulse.
        @(negedge clk);
        a = 8'd200;
        b = 8'd50;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort busy", busy, 1'b0);
        check_eq("abort done", done, 1'b0);
        check_eq("abort diff", diff, 8'h00);
        check_eq("abort borrow", borrow_out, 1'b0);
        check_eq("abort ovf", ovf, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check_eq("abort no_activity", dones, 0);
        run_op(8'd200, 8'd50, 8'd150, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
